// File: rtl/midi_note_tracker.sv
// midi_note_tracker
// Keeps a table of currently held MIDI notes, fed by the note events that
// midi_decode produces. Each accepted event is resolved by a sequential scan
// over all slots (one slot per clock), followed by a single apply cycle that
// performs the table write.
//
// Event interface: event_valid_in is a one-cycle strobe with no ready signal.
// The tracker accepts a strobe only while busy_out is low (IDLE). A strobe
// that passes the channel filter while busy_out is high is discarded, and
// drop_out pulses in the following cycle. Strobes that fail the channel filter
// are ignored without any indication.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   event_valid_in    one-cycle note event strobe
//   status_in         1 = note-on, 0 = note-off
//   channel_in        MIDI channel
//   note_in           note number (bit 7 ignored)
//   velocity_in       velocity (bit 7 ignored)
//   panic_in          all-notes-off request
//   busy_out          high while an event is being processed
//   active_out        per-slot valid bits
//   notes_out         slot k note at [7k+6:7k]
//   velocities_out    slot k velocity at [7k+6:7k]
//   channels_out      slot k channel at [4k+3:4k]
//   active_count_out  number of valid slots
//   update_out        one-cycle pulse when the table changed
//   drop_out          one-cycle pulse when an event was discarded
//   state_out         FSM state (0 IDLE, 1 SCAN, 2 APPLY), for observation
module midi_note_tracker #(
   parameter int NUM_SLOTS      = 8,
   parameter int OMNI           = 1,
   parameter int LISTEN_CHANNEL = 0
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           event_valid_in,
   input  logic                           status_in,
   input  logic [3:0]                     channel_in,
   input  logic [7:0]                     note_in,
   input  logic [7:0]                     velocity_in,
   input  logic                           panic_in,
   output logic                           busy_out,
   output logic [NUM_SLOTS-1:0]           active_out,
   output logic [7*NUM_SLOTS-1:0]         notes_out,
   output logic [7*NUM_SLOTS-1:0]         velocities_out,
   output logic [4*NUM_SLOTS-1:0]         channels_out,
   output logic [$clog2(NUM_SLOTS+1)-1:0] active_count_out,
   output logic                           update_out,
   output logic                           drop_out,
   output logic [1:0]                     state_out
);

   localparam int IW = $clog2(NUM_SLOTS);
   localparam int CW = $clog2(NUM_SLOTS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t state_q, state_d;

   // latched event
   logic          lat_on_q;
   logic [3:0]    lat_ch_q;
   logic [6:0]    lat_note_q;
   logic [6:0]    lat_vel_q;

   // scan results
   logic [IW-1:0] idx_q;
   logic          match_found_q, free_found_q;
   logic [IW-1:0] match_idx_q, free_idx_q;
   logic [IW-1:0] steal_q;

   // note table
   logic [NUM_SLOTS-1:0] valid_q;
   logic [6:0]           note_q [NUM_SLOTS];
   logic [6:0]           vel_q  [NUM_SLOTS];
   logic [3:0]           ch_q   [NUM_SLOTS];
   logic [CW-1:0]        count_q;

   logic update_q, drop_q;

   logic chan_ok, accept, hit, empty_slot;
   logic unused_bits;

   assign unused_bits = note_in[7] ^ velocity_in[7];

   assign chan_ok    = (OMNI != 0) || (channel_in == 4'(LISTEN_CHANNEL));
   assign accept     = (state_q == IDLE) && event_valid_in && chan_ok && !panic_in;
   assign hit        = valid_q[idx_q] && (note_q[idx_q] == lat_note_q) && (ch_q[idx_q] == lat_ch_q);
   assign empty_slot = !valid_q[idx_q];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (idx_q == LAST_IDX) state_d = APPLY;
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (panic_in) state_d = IDLE;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= IDLE;
         lat_on_q      <= 1'b0;
         lat_ch_q      <= '0;
         lat_note_q    <= '0;
         lat_vel_q     <= '0;
         idx_q         <= '0;
         match_found_q <= 1'b0;
         free_found_q  <= 1'b0;
         match_idx_q   <= '0;
         free_idx_q    <= '0;
         steal_q       <= '0;
         valid_q       <= '0;
         count_q       <= '0;
         update_q      <= 1'b0;
         drop_q        <= 1'b0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            note_q[k] <= '0;
            vel_q[k]  <= '0;
            ch_q[k]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         update_q <= 1'b0;
         drop_q   <= 1'b0;
         if (panic_in) begin
            // update only reported if something was actually held
            update_q <= |valid_q;
            valid_q  <= '0;
            count_q  <= '0;
            steal_q  <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
               note_q[k] <= '0;
               vel_q[k]  <= '0;
               ch_q[k]   <= '0;
            end
         end else begin
            if ((state_q != IDLE) && event_valid_in && chan_ok) drop_q <= 1'b1;
            case (state_q)
               IDLE: begin
                  if (accept) begin
                     // note-on with zero velocity is a note-off
                     lat_on_q      <= status_in && (velocity_in[6:0] != 7'd0);
                     lat_ch_q      <= channel_in;
                     lat_note_q    <= note_in[6:0];
                     lat_vel_q     <= velocity_in[6:0];
                     idx_q         <= '0;
                     match_found_q <= 1'b0;
                     free_found_q  <= 1'b0;
                  end
               end
               SCAN: begin
                  if (hit && !match_found_q) begin
                     match_found_q <= 1'b1;
                     match_idx_q   <= idx_q;
                  end
                  if (empty_slot && !free_found_q) begin
                     free_found_q <= 1'b1;
                     free_idx_q   <= idx_q;
                  end
                  idx_q <= idx_q + IW'(1);
               end
               APPLY: begin
                  if (lat_on_q) begin
                     update_q <= 1'b1;
                     if (match_found_q) begin
                        vel_q[match_idx_q] <= lat_vel_q;
                     end else if (free_found_q) begin
                        valid_q[free_idx_q] <= 1'b1;
                        note_q[free_idx_q]  <= lat_note_q;
                        vel_q[free_idx_q]   <= lat_vel_q;
                        ch_q[free_idx_q]    <= lat_ch_q;
                        count_q             <= count_q + CW'(1);
                     end else begin
                        // table full: steal round-robin, slot stays valid
                        note_q[steal_q] <= lat_note_q;
                        vel_q[steal_q]  <= lat_vel_q;
                        ch_q[steal_q]   <= lat_ch_q;
                        steal_q         <= (steal_q == LAST_IDX) ? '0 : steal_q + IW'(1);
                     end
                  end else if (match_found_q) begin
                     update_q             <= 1'b1;
                     valid_q[match_idx_q] <= 1'b0;
                     note_q[match_idx_q]  <= '0;
                     vel_q[match_idx_q]   <= '0;
                     ch_q[match_idx_q]    <= '0;
                     count_q              <= count_q - CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      notes_out      = '0;
      velocities_out = '0;
      channels_out   = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         notes_out[7*k +: 7]      = note_q[k];
         velocities_out[7*k +: 7] = vel_q[k];
         channels_out[4*k +: 4]   = ch_q[k];
      end
   end

   assign busy_out         = (state_q != IDLE);
   assign active_out       = valid_q;
   assign active_count_out = count_q;
   assign update_out       = update_q;
   assign drop_out         = drop_q;
   assign state_out        = state_q;

endmodule

// File: tb/tb_midi_note_tracker.sv
module tb_midi_note_tracker;
   localparam int N  = 8;
   localparam int SW = N + 7*N + 7*N + 4*N + 4;

   // ---------------- clock / reset ----------------
   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic       rst_in = 1'b1;
   logic       event_valid_in = 1'b0;
   logic       ev2_valid = 1'b0;
   logic       status_in = 1'b0;
   logic [3:0] channel_in = '0;
   logic [7:0] note_in = '0;
   logic [7:0] velocity_in = '0;
   logic       panic_in = 1'b0;

   logic           busy_out, update_out, drop_out;
   logic [N-1:0]   active_out;
   logic [7*N-1:0] notes_out, velocities_out;
   logic [4*N-1:0] channels_out;
   logic [3:0]     active_count_out;
   logic [1:0]     state_out;

   logic           d2_busy, d2_update, d2_drop;
   logic [N-1:0]   d2_active;
   logic [7*N-1:0] d2_notes, d2_vels;
   logic [4*N-1:0] d2_chans;
   logic [3:0]     d2_count;
   logic [1:0]     d2_state;

   midi_note_tracker #(.NUM_SLOTS(N), .OMNI(1), .LISTEN_CHANNEL(0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .event_valid_in(event_valid_in),
      .status_in(status_in), .channel_in(channel_in), .note_in(note_in),
      .velocity_in(velocity_in), .panic_in(panic_in), .busy_out(busy_out),
      .active_out(active_out), .notes_out(notes_out), .velocities_out(velocities_out),
      .channels_out(channels_out), .active_count_out(active_count_out),
      .update_out(update_out), .drop_out(drop_out), .state_out(state_out)
   );

   midi_note_tracker #(.NUM_SLOTS(N), .OMNI(0), .LISTEN_CHANNEL(3)) dut2 (
      .clk_in(clk_in), .rst_in(rst_in), .event_valid_in(ev2_valid),
      .status_in(status_in), .channel_in(channel_in), .note_in(note_in),
      .velocity_in(velocity_in), .panic_in(panic_in), .busy_out(d2_busy),
      .active_out(d2_active), .notes_out(d2_notes), .velocities_out(d2_vels),
      .channels_out(d2_chans), .active_count_out(d2_count),
      .update_out(d2_update), .drop_out(d2_drop), .state_out(d2_state)
   );

   // ---------------- scoreboard / model ----------------
   logic [SW-1:0] exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   logic       m_valid [N];
   logic [6:0] m_note  [N];
   logic [6:0] m_vel   [N];
   logic [3:0] m_ch    [N];
   int         m_steal;

   function automatic logic [SW-1:0] dut_snap();
      return {active_out, notes_out, velocities_out, channels_out, active_count_out};
   endfunction

   function automatic logic [SW-1:0] model_snap();
      logic [N-1:0]   a;
      logic [7*N-1:0] n, v;
      logic [4*N-1:0] c;
      int cnt;
      cnt = 0;
      for (int k = 0; k < N; k++) begin
         a[k] = m_valid[k];
         n[7*k +: 7] = m_note[k];
         v[7*k +: 7] = m_vel[k];
         c[4*k +: 4] = m_ch[k];
         if (m_valid[k]) cnt++;
      end
      return {a, n, v, c, 4'(cnt)};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_valid[k] = 1'b0; m_note[k] = '0; m_vel[k] = '0; m_ch[k] = '0;
      end
      m_steal = 0;
      exp_q.delete();
   endtask

   task automatic model_apply(input logic on, input logic [3:0] ch, input logic [7:0] note,
                              input logic [7:0] vel, output logic chg);
      logic [6:0] n, v;
      int m, f;
      n = note[6:0]; v = vel[6:0]; m = -1; f = -1; chg = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (m < 0 && m_valid[k] && m_note[k] == n && m_ch[k] == ch) m = k;
         if (f < 0 && !m_valid[k]) f = k;
      end
      if (on && v != 7'd0) begin
         chg = 1'b1;
         if (m >= 0) m_vel[m] = v;
         else if (f >= 0) begin
            m_valid[f] = 1'b1; m_note[f] = n; m_vel[f] = v; m_ch[f] = ch;
         end else begin
            m_note[m_steal] = n; m_vel[m_steal] = v; m_ch[m_steal] = ch;
            m_steal = (m_steal + 1) % N;
         end
      end else if (m >= 0) begin
         chg = 1'b1;
         m_valid[m] = 1'b0; m_note[m] = '0; m_vel[m] = '0; m_ch[m] = '0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_in = 1'b1; event_valid_in = 1'b0; ev2_valid = 1'b0; panic_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;
      model_reset();
   endtask

   // Strobes an event in cycle 0 (called at a negedge), optionally a second
   // strobe at cycle extra_at, and returns per-cycle busy/drop traces plus
   // the table and update_out seen in cycle N+2. The expected table is
   // pushed before driving and popped when the result is sampled.
   task automatic run_event(input logic on, input logic [3:0] ch, input logic [7:0] note,
                            input logic [7:0] vel, input int extra_at,
                            output logic [15:0] busy_m, output logic [15:0] drop_m,
                            output logic upd, output logic [SW-1:0] obs,
                            output logic [SW-1:0] exp, output logic exp_chg);
      model_apply(on, ch, note, vel, exp_chg);
      exp_q.push_back(model_snap());
      status_in = on; channel_in = ch; note_in = note; velocity_in = vel;
      event_valid_in = 1'b1;
      busy_m = '0; drop_m = '0; upd = 1'b0; obs = '0;
      for (int k = 1; k <= N + 2; k++) begin
         @(negedge clk_in);
         event_valid_in = (k == extra_at);
         if (k == extra_at) note_in = note + 8'd1;
         busy_m[k] = busy_out;
         drop_m[k] = drop_out;
         if (k == N + 2) begin
            upd = update_out;
            obs = dut_snap();
         end
      end
      exp = exp_q.pop_front();
   endtask

   logic [15:0]   bm, dm;
   logic          up, ec;
   logic [SW-1:0] ob, ex;

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      tests_run++;
      if (dut_snap() !== '0) begin
         tests_failed++; $display("FAIL reset_table got=%h exp=0", dut_snap());
      end
      tests_run++;
      if ({busy_out, update_out, drop_out} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_flags got=%b exp=000", {busy_out, update_out, drop_out});
      end
   endtask

   task automatic test_basic();
      do_reset();
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (bm !== 16'h03FE) begin tests_failed++; $display("FAIL basic_busy got=%h exp=03fe", bm); end
      tests_run++;
      if (up !== 1'b1 || dm !== 16'h0) begin tests_failed++; $display("FAIL basic_upd_drop got=%b/%h exp=1/0", up, dm); end
      tests_run++;
      if (ob !== ex) begin tests_failed++; $display("FAIL basic_table got=%h exp=%h", ob, ex); end
      tests_run++;
      if (active_out !== 8'h01 || notes_out[6:0] !== 7'd60 || velocities_out[6:0] !== 7'd100 || active_count_out !== 4'd1) begin
         tests_failed++;
         $display("FAIL basic_slot0 got=%h/%0d/%0d/%0d exp=01/60/100/1", active_out, notes_out[6:0], velocities_out[6:0], active_count_out);
      end
   endtask

   task automatic test_note_off();
      do_reset();
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      run_event(1'b1, 4'd0, 8'd64, 8'd80, -1, bm, dm, up, ob, ex, ec);
      run_event(1'b0, 4'd0, 8'd60, 8'd0, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || up !== 1'b1) begin tests_failed++; $display("FAIL off_table got=%h/%b exp=%h/1", ob, up, ex); end
      tests_run++;
      if (active_out !== 8'h02 || notes_out[13:7] !== 7'd64 || active_count_out !== 4'd1) begin
         tests_failed++; $display("FAIL off_slot1 got=%h/%0d/%0d exp=02/64/1", active_out, notes_out[13:7], active_count_out);
      end
      run_event(1'b0, 4'd0, 8'd72, 8'd0, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (up !== 1'b0 || ob !== ex) begin tests_failed++; $display("FAIL off_nomatch got=%b/%h exp=0/%h", up, ob, ex); end
      // same note on another channel occupies its own slot
      run_event(1'b1, 4'd9, 8'd64, 8'd33, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || up !== 1'b1) begin tests_failed++; $display("FAIL off_otherch got=%h exp=%h", ob, ex); end
   endtask

   task automatic test_retrigger();
      do_reset();
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      run_event(1'b1, 4'd0, 8'd60, 8'd0, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || up !== 1'b1 || active_count_out !== 4'd0) begin
         tests_failed++; $display("FAIL vel0_off got=%h/%b exp=%h/1", ob, up, ex);
      end
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      run_event(1'b1, 4'd0, 8'd60, 8'd50, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || velocities_out[6:0] !== 7'd50 || active_count_out !== 4'd1) begin
         tests_failed++; $display("FAIL retrig got=%h exp=%h", ob, ex);
      end
      run_event(1'b1, 4'd0, 8'd60, 8'hB2, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (up !== 1'b1 || ob !== ex) begin tests_failed++; $display("FAIL retrig_same got=%b/%h exp=1/%h", up, ob, ex); end
   endtask

   task automatic test_steal();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         run_event(1'b1, 4'(i % 2), 8'(60 + i), 8'($urandom_range(1, 127)), -1, bm, dm, up, ob, ex, ec);
         tests_run++;
         if (ob !== ex || up !== 1'b1) begin tests_failed++; $display("FAIL steal_%0d got=%h exp=%h", i, ob, ex); end
      end
      tests_run++;
      if (notes_out[6:0] !== 7'd68 || notes_out[13:7] !== 7'd69 || notes_out[20:14] !== 7'd62 || active_count_out !== 4'd8) begin
         tests_failed++;
         $display("FAIL steal_slots got=%0d/%0d/%0d/%0d exp=68/69/62/8", notes_out[6:0], notes_out[13:7], notes_out[20:14], active_count_out);
      end
      // panic clears the steal pointer: a refill then steals slot 0 again
      panic_in = 1'b1; @(negedge clk_in); panic_in = 1'b0;
      model_reset();
      for (int i = 0; i < 9; i++) run_event(1'b1, 4'd2, 8'(20 + i), 8'd7, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || notes_out[6:0] !== 7'd28) begin tests_failed++; $display("FAIL steal_ptr_reset got=%h exp=%h", ob, ex); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_event(1'b1, 4'd0, 8'd60, 8'd100, 4, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (dm !== 16'h0020 || bm !== 16'h03FE) begin tests_failed++; $display("FAIL b2b_drop got=%h/%h exp=0020/03fe", dm, bm); end
      tests_run++;
      if (ob !== ex || up !== 1'b1) begin tests_failed++; $display("FAIL b2b_table got=%h exp=%h", ob, ex); end
      // strobed in cycle N+2 of the previous event
      run_event(1'b1, 4'd1, 8'd62, 8'd90, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || up !== 1'b1 || bm !== 16'h03FE) begin tests_failed++; $display("FAIL b2b_next got=%h exp=%h", ob, ex); end
   endtask

   task automatic test_filter();
      logic seen_busy, seen_drop, seen_upd;
      do_reset();
      seen_busy = 1'b0; seen_drop = 1'b0; seen_upd = 1'b0;
      status_in = 1'b1; channel_in = 4'd5; note_in = 8'd60; velocity_in = 8'd100; ev2_valid = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_in);
         ev2_valid = 1'b0;
         if (d2_busy) seen_busy = 1'b1;
         if (d2_drop) seen_drop = 1'b1;
         if (d2_update) seen_upd = 1'b1;
      end
      tests_run++;
      if ({seen_busy, seen_drop, seen_upd} !== 3'b000 || d2_active !== 8'h00) begin
         tests_failed++; $display("FAIL filter_ignore got=%b/%h exp=000/00", {seen_busy, seen_drop, seen_upd}, d2_active);
      end
      channel_in = 4'd3; ev2_valid = 1'b1;
      @(negedge clk_in);
      ev2_valid = 1'b0;
      tests_run++;
      if (d2_busy !== 1'b1) begin tests_failed++; $display("FAIL filter_busy got=%b exp=1", d2_busy); end
      for (int k = 2; k <= N + 2; k++) @(negedge clk_in);
      tests_run++;
      if (d2_update !== 1'b1 || d2_active !== 8'h01 || d2_notes[6:0] !== 7'd60 || d2_chans[3:0] !== 4'd3) begin
         tests_failed++; $display("FAIL filter_accept got=%b/%h/%0d exp=1/01/60", d2_update, d2_active, d2_notes[6:0]);
      end
   endtask

   task automatic test_reset_mid_scan();
      logic seen_upd;
      do_reset();
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      status_in = 1'b1; channel_in = 4'd0; note_in = 8'd61; velocity_in = 8'd90; event_valid_in = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_in);
         event_valid_in = 1'b0;
      end
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      model_reset();
      tests_run++;
      if (dut_snap() !== '0 || {busy_out, update_out, drop_out} !== 3'b000) begin
         tests_failed++; $display("FAIL rst_mid got=%h/%b exp=0/000", dut_snap(), {busy_out, update_out, drop_out});
      end
      seen_upd = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_in);
         if (update_out) seen_upd = 1'b1;
      end
      tests_run++;
      if (seen_upd !== 1'b0 || dut_snap() !== '0) begin tests_failed++; $display("FAIL rst_mid_quiet got=%b exp=0", seen_upd); end
   endtask

   task automatic test_panic();
      logic seen_upd;
      do_reset();
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      run_event(1'b1, 4'd4, 8'd64, 8'd80, -1, bm, dm, up, ob, ex, ec);
      run_event(1'b1, 4'd0, 8'd67, 8'd70, -1, bm, dm, up, ob, ex, ec);
      panic_in = 1'b1;
      @(negedge clk_in);
      panic_in = 1'b0;
      model_reset();
      tests_run++;
      if (active_count_out !== 4'd0 || active_out !== 8'h00 || update_out !== 1'b1) begin
         tests_failed++; $display("FAIL panic_clear got=%0d/%h/%b exp=0/00/1", active_count_out, active_out, update_out);
      end
      tests_run++;
      if (dut_snap() !== model_snap()) begin tests_failed++; $display("FAIL panic_fields got=%h exp=%h", dut_snap(), model_snap()); end
      panic_in = 1'b1;
      @(negedge clk_in);
      panic_in = 1'b0;
      tests_run++;
      if (update_out !== 1'b0) begin tests_failed++; $display("FAIL panic_empty got=%b exp=0", update_out); end
      // panic during a scan, with a strobe in the same cycle
      run_event(1'b1, 4'd0, 8'd60, 8'd100, -1, bm, dm, up, ob, ex, ec);
      status_in = 1'b1; note_in = 8'd61; event_valid_in = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_in);
         event_valid_in = 1'b0;
      end
      panic_in = 1'b1; event_valid_in = 1'b1; note_in = 8'd62;
      @(negedge clk_in);
      panic_in = 1'b0; event_valid_in = 1'b0;
      model_reset();
      tests_run++;
      if ({busy_out, update_out, drop_out} !== 3'b010 || active_out !== 8'h00) begin
         tests_failed++; $display("FAIL panic_scan got=%b/%h exp=010/00", {busy_out, update_out, drop_out}, active_out);
      end
      seen_upd = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_in);
         if (update_out || busy_out) seen_upd = 1'b1;
      end
      tests_run++;
      if (seen_upd !== 1'b0) begin tests_failed++; $display("FAIL panic_abandon got=%b exp=0", seen_upd); end
      run_event(1'b1, 4'd0, 8'd70, 8'd20, -1, bm, dm, up, ob, ex, ec);
      tests_run++;
      if (ob !== ex || up !== 1'b1) begin tests_failed++; $display("FAIL panic_after got=%h exp=%h", ob, ex); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_note_off();
      test_retrigger();
      test_steal();
      test_back_to_back();
      test_filter();
      test_reset_mid_scan();
      test_panic();
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
